// File: rtl/imem_server.sv
// imem_server: word-addressed instruction memory for the fetch stage.
// Requests are admitted against a credit pool sized to the response FIFO.
// Each accepted read travels a fixed-latency valid pipeline and then waits
// in the FIFO until the fetch side pops it. A flush drops everything in flight.
module imem_server #(
    parameter int          DEPTH_LOG2 = 10,
    parameter int          LATENCY    = 2,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0013
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [31:0]           i_req_addr,
    input  logic                  i_flush,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [31:0]           o_rsp_addr,
    output logic [31:0]           o_rsp_data,
    output logic                  o_rsp_err,
    input  logic                  i_wr_en,
    input  logic [DEPTH_LOG2-1:0] i_wr_addr,
    input  logic [31:0]           i_wr_data
);

    localparam int               MEM_WORDS  = 1 << DEPTH_LOG2;
    localparam int               CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int               PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ZERO   = {PTR_W{1'b0}};

    logic [31:0]           mem_r       [MEM_WORDS];

    logic                  pipe_vld_r  [LATENCY];
    logic [31:0]           pipe_addr_r [LATENCY];
    logic [31:0]           pipe_data_r [LATENCY];
    logic                  pipe_err_r  [LATENCY];

    logic [31:0]           fifo_addr_r [FIFO_DEPTH];
    logic [31:0]           fifo_data_r [FIFO_DEPTH];
    logic                  fifo_err_r  [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [CNT_W-1:0]      fifo_cnt_r;
    logic [CNT_W-1:0]      fifo_cnt_nxt_s;
    logic [CNT_W-1:0]      credits_r;
    logic [CNT_W-1:0]      credits_nxt_s;
    logic                  rsp_valid_r;

    logic                  accept_s;
    logic                  pop_s;
    logic                  push_s;
    logic                  rd_err_s;
    logic [DEPTH_LOG2-1:0] rd_idx_s;

    // Advance a FIFO pointer, wrapping at the last entry.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        ptr_inc = (ptr == PTR_LAST) ? PTR_ZERO : (ptr + PTR_W'(1));
    endfunction

    // Ready is withheld during a flush so nothing new enters the cleared pipe.
    assign o_req_ready = (credits_r != CNT_ZERO) & ~i_flush;

    // Response port is driven straight from registered FIFO head storage.
    assign o_rsp_valid = rsp_valid_r;
    assign o_rsp_addr  = fifo_addr_r[rd_ptr_r];
    assign o_rsp_data  = fifo_data_r[rd_ptr_r];
    assign o_rsp_err   = fifo_err_r[rd_ptr_r];

    // Handshake qualifiers and request address decode.
    always_comb begin
        accept_s = i_req_valid & o_req_ready;
        pop_s    = rsp_valid_r & i_rsp_ready & ~i_flush;
        push_s   = pipe_vld_r[LATENCY-1];
        rd_idx_s = i_req_addr[DEPTH_LOG2-1:0];
        rd_err_s = |i_req_addr[31:DEPTH_LOG2];
    end

    // Next FIFO occupancy and credit count; a flush restores both outright.
    always_comb begin
        fifo_cnt_nxt_s = fifo_cnt_r;
        credits_nxt_s  = credits_r;
        if (i_flush) begin
            fifo_cnt_nxt_s = CNT_ZERO;
            credits_nxt_s  = CREDIT_MAX;
        end else begin
            case ({push_s, pop_s})
                2'b10:   fifo_cnt_nxt_s = fifo_cnt_r + CNT_ONE;
                2'b01:   fifo_cnt_nxt_s = fifo_cnt_r - CNT_ONE;
                default: fifo_cnt_nxt_s = fifo_cnt_r;
            endcase
            case ({accept_s, pop_s})
                2'b10:   credits_nxt_s = credits_r - CNT_ONE;
                2'b01:   credits_nxt_s = credits_r + CNT_ONE;
                default: credits_nxt_s = credits_r;
            endcase
        end
    end

    // Program image array; contents survive reset so a loaded image persists.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            mem_r[i_wr_addr] <= i_wr_data;
        end
    end

    // Read pipeline: stage 0 samples the array (old word on a same-edge write),
    // later stages shift; flush kills every in-flight valid.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < LATENCY; k++) begin
                pipe_vld_r[k]  <= 1'b0;
                pipe_addr_r[k] <= 32'h0000_0000;
                pipe_data_r[k] <= 32'h0000_0000;
                pipe_err_r[k]  <= 1'b0;
            end
        end else begin
            pipe_vld_r[0] <= accept_s;
            if (accept_s) begin
                pipe_addr_r[0] <= i_req_addr;
                pipe_data_r[0] <= rd_err_s ? NOP_WORD : mem_r[rd_idx_s];
                pipe_err_r[0]  <= rd_err_s;
            end
            for (int k = 1; k < LATENCY; k++) begin
                pipe_vld_r[k]  <= pipe_vld_r[k-1] & ~i_flush;
                pipe_addr_r[k] <= pipe_addr_r[k-1];
                pipe_data_r[k] <= pipe_data_r[k-1];
                pipe_err_r[k]  <= pipe_err_r[k-1];
            end
        end
    end

    // Response FIFO storage, pointers, occupancy and credits.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                fifo_addr_r[k] <= 32'h0000_0000;
                fifo_data_r[k] <= 32'h0000_0000;
                fifo_err_r[k]  <= 1'b0;
            end
            wr_ptr_r    <= PTR_ZERO;
            rd_ptr_r    <= PTR_ZERO;
            fifo_cnt_r  <= CNT_ZERO;
            credits_r   <= CREDIT_MAX;
            rsp_valid_r <= 1'b0;
        end else begin
            fifo_cnt_r  <= fifo_cnt_nxt_s;
            credits_r   <= credits_nxt_s;
            rsp_valid_r <= (fifo_cnt_nxt_s != CNT_ZERO);
            if (i_flush) begin
                wr_ptr_r <= PTR_ZERO;
                rd_ptr_r <= PTR_ZERO;
            end else begin
                if (push_s) begin
                    fifo_addr_r[wr_ptr_r] <= pipe_addr_r[LATENCY-1];
                    fifo_data_r[wr_ptr_r] <= pipe_data_r[LATENCY-1];
                    fifo_err_r[wr_ptr_r]  <= pipe_err_r[LATENCY-1];
                    wr_ptr_r              <= ptr_inc(wr_ptr_r);
                end
                if (pop_s) begin
                    rd_ptr_r <= ptr_inc(rd_ptr_r);
                end
            end
        end
    end

endmodule
